instr_fetch_queue: RTL and testbench

//  Fetch stage feeding the 16-bit CPU datapath. Reads big-endian instructions one byte at a

---
 rtl/instr_fetch_queue_pkg.sv | 24 ++
 rtl/instr_fetch_queue_fifo.sv | 60 ++++++
 rtl/instr_fetch_queue.sv | 158 +++++++++++++++
 tb/tb_instr_fetch_queue.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   INSTR_W / BYTE_W   : instruction and memory-port data widths
//   RESET_PC_DEFAULT   : default PC of the first fetch after reset
//   fetch_state_e      : fetch FSM encoding (idle, fetching high byte, fetching low byte)
//   fetch_entry_t      : one queued instruction together with its PC
package instr_fetch_queue_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 16'd10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReqHi = 2'd1,
        StReqLo = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO of fetched instructions with their PCs.
//   Clock, Reset : clock and synchronous active-high reset
//   push, wdata  : enqueue an entry (ignored while full or flushing)
//   pop          : dequeue the head (ignored while empty or flushing)
//   flush        : discard every entry; wins over push and pop
//   full, empty  : occupancy flags
//   count        : number of stored entries
//   head         : oldest entry (undefined content when empty)
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  fetch_entry_t     wdata,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock) begin
        if (Reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: reads big-endian 16-bit instructions one byte per req/ack beat, queues them
// with their PCs and hands them to decode over valid/ready. A redirect flushes the queue.
//   Clock, Reset          : clock and synchronous active-high reset
//   mem_req, mem_addr     : byte read request and address (held until mem_ack)
//   mem_ack, mem_rdata    : read completion and byte data
//   redirect, redirect_pc : taken branch; fetch restarts at redirect_pc with bit 0 cleared
//   instr_valid, instr,
//   instr_pc              : queue head (instr/instr_pc read 0 when empty)
//   instr_ready           : decode accepts the head
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic               mem_req,
    output logic [15:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [BYTE_W-1:0]  mem_rdata,
    input  logic               redirect,
    input  logic [15:0]        redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [15:0]        instr_pc,
    input  logic               instr_ready
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    fetch_state_e      state_q;
    logic [15:0]       fetch_pc_q;
    logic [BYTE_W-1:0] hi_q;
    logic              drop_q;
    logic              mem_req_q;
    logic [15:0]       mem_addr_q;

    logic              fire;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              room;
    fetch_entry_t      wdata;
    fetch_entry_t      head;
    logic [15:0]       new_pc;
    logic [15:0]       pc_plus1;
    logic [15:0]       pc_plus2;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[0];

    assign fire     = mem_req_q & mem_ack;
    assign new_pc   = {redirect_pc[15:1], 1'b0};
    assign pc_plus1 = fetch_pc_q + 16'd1;
    assign pc_plus2 = fetch_pc_q + 16'd2;

    // A redirect discards both the completing push and any pop of that cycle.
    assign push  = (state_q == StReqLo) & fire & ~drop_q & ~redirect;
    assign pop   = instr_valid & instr_ready & ~redirect;
    assign wdata = '{pc: fetch_pc_q, instr: {hi_q, mem_rdata}};

    assign count_next = count + CNT_W'(push) - CNT_W'(pop);
    assign room       = (count_next < CNT_W'(QDEPTH));

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .flush (redirect),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    assign instr_valid = ~empty;
    assign instr       = empty ? '0 : head.instr;
    assign instr_pc    = empty ? '0 : head.pc;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

    // mem_req/mem_addr are registered so an in-flight request never changes before its ack.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            hi_q       <= '0;
            drop_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else if (redirect) begin
            fetch_pc_q <= new_pc;
            if (state_q == StIdle || fire) begin
                state_q    <= StReqHi;
                mem_req_q  <= 1'b1;
                mem_addr_q <= new_pc;
                drop_q     <= 1'b0;
            end else begin
                // Request still outstanding: let it finish, then throw its byte away.
                drop_q <= 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (!full) begin
                        state_q    <= StReqHi;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                StReqHi: begin
                    if (fire) begin
                        if (drop_q) begin
                            drop_q     <= 1'b0;
                            mem_addr_q <= fetch_pc_q;
                        end else begin
                            hi_q       <= mem_rdata;
                            state_q    <= StReqLo;
                            mem_addr_q <= pc_plus1;
                        end
                    end
                end
                StReqLo: begin
                    if (fire) begin
                        if (drop_q) begin
                            drop_q     <= 1'b0;
                            state_q    <= StReqHi;
                            mem_addr_q <= fetch_pc_q;
                        end else begin
                            fetch_pc_q <= pc_plus2;
                            mem_addr_q <= pc_plus2;
                            if (room) begin
                                state_q <= StReqHi;
                            end else begin
                                state_q   <= StIdle;
                                mem_req_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a byte memory model with programmable ack latency
// and a stall switch, plus one task per scenario with inline checks.
module tb_instr_fetch_queue;

    logic        Clock;
    logic        Reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;

    int n_vec;
    int n_err;
    int ack_wait;
    int wait_cnt;
    logic ack_en;

    instr_fetch_queue #(
        .RESET_PC (16'd10),
        .QDEPTH   (4)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        case (a)
            16'd10:  return 8'h12;
            16'd11:  return 8'h34;
            16'd12:  return 8'hAB;
            16'd13:  return 8'hCD;
            default: return a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [15:0] exp_instr(input logic [15:0] pc);
        logic [15:0] pc1;
        pc1 = pc + 16'd1;
        return {exp_byte(pc), exp_byte(pc1)};
    endfunction

    // Memory model: ack after ack_wait extra cycles of a held request.
    assign mem_rdata = exp_byte(mem_addr);
    assign mem_ack   = ack_en && mem_req && (wait_cnt >= ack_wait);

    always @(posedge Clock) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset;
        Reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'd0;
        instr_ready = 1'b0;
        ack_en      = 1'b1;
        ack_wait    = 0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({mem_req, mem_addr} !== {1'b0, 16'd10}) begin
            n_err++;
            $display("FAIL reset_mem: got %h want %h", {mem_req, mem_addr}, {1'b0, 16'd10});
        end
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== 33'd0) begin
            n_err++;
            $display("FAIL reset_out: got %h want %h", {instr_valid, instr, instr_pc}, 33'd0);
        end
        Reset = 1'b0;
    endtask

    task automatic test_zero_wait;
        do_reset();
        instr_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'd11, 1'b0}) begin
            n_err++;
            $display("FAIL zw_cycle3: got %h want %h", {mem_req, mem_addr, instr_valid},
                     {1'b1, 16'd11, 1'b0});
        end
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h1234, 16'd10}) begin
            n_err++;
            $display("FAIL zw_first: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, 16'h1234, 16'd10});
        end
        tick();
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zw_gap: got %h want %h", instr_valid, 1'b0);
        end
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hABCD, 16'd12}) begin
            n_err++;
            $display("FAIL zw_second: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, 16'hABCD, 16'd12});
        end
        tick();
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, exp_instr(16'd14), 16'd14}) begin
            n_err++;
            $display("FAIL zw_third: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, exp_instr(16'd14), 16'd14});
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] exp_pc;
        do_reset();
        repeat (9) tick();
        n_vec++;
        if ({mem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 16'd10}) begin
            n_err++;
            $display("FAIL bp_full: got %h want %h", {mem_req, instr_valid, instr_pc},
                     {1'b0, 1'b1, 16'd10});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL bp_stall[%0d]: got %h want %h", i, mem_req, 1'b0);
            end
        end
        instr_ready = 1'b1;
        exp_pc = 16'd12;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 1) begin
                n_vec++;
                if ({mem_req, mem_addr} !== {1'b1, 16'd18}) begin
                    n_err++;
                    $display("FAIL bp_resume: got %h want %h", {mem_req, mem_addr},
                             {1'b1, 16'd18});
                end
            end
            if (instr_valid && instr_ready) begin
                n_vec++;
                if ({instr_pc, instr} !== {exp_pc, exp_instr(exp_pc)}) begin
                    n_err++;
                    $display("FAIL bp_order: got %h want %h", {instr_pc, instr},
                             {exp_pc, exp_instr(exp_pc)});
                end
                exp_pc = exp_pc + 16'd2;
            end
        end
        n_vec++;
        if (exp_pc !== 16'd30) begin
            n_err++;
            $display("FAIL bp_popcount: got next pc %h want %h", exp_pc, 16'd30);
        end
    endtask

    task automatic test_latency;
        do_reset();
        instr_ready = 1'b1;
        ack_wait    = 2;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({mem_req, mem_addr} !== {1'b1, 16'd10}) begin
                n_err++;
                $display("FAIL lat_hold[%0d]: got %h want %h", i, {mem_req, mem_addr},
                         {1'b1, 16'd10});
            end
        end
        tick();
        n_vec++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'd11, 1'b0}) begin
            n_err++;
            $display("FAIL lat_lo: got %h want %h", {mem_req, mem_addr, instr_valid},
                     {1'b1, 16'd11, 1'b0});
        end
        tick();
        tick();
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h1234, 16'd10}) begin
            n_err++;
            $display("FAIL lat_first: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, 16'h1234, 16'd10});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL lat_extra[%0d]: got %h want %h", i, instr_valid, 1'b0);
            end
        end
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hABCD, 16'd12}) begin
            n_err++;
            $display("FAIL lat_second: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, 16'hABCD, 16'd12});
        end
    endtask

    task automatic test_redirect_drop;
        do_reset();
        tick();
        tick();
        // REQ_LO at address 11: stall the memory and redirect twice.
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0031;
        tick();
        redirect_pc = 16'h0041;
        tick();
        redirect = 1'b0;
        n_vec++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'd11, 1'b0}) begin
            n_err++;
            $display("FAIL rd_held: got %h want %h", {mem_req, mem_addr, instr_valid},
                     {1'b1, 16'd11, 1'b0});
        end
        tick();
        n_vec++;
        if ({mem_req, mem_addr} !== {1'b1, 16'd11}) begin
            n_err++;
            $display("FAIL rd_held2: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'd11});
        end
        ack_en = 1'b1;
        tick();
        n_vec++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            n_err++;
            $display("FAIL rd_restart: got %h want %h", {mem_req, mem_addr, instr_valid},
                     {1'b1, 16'h0040, 1'b0});
        end
        instr_ready = 1'b1;
        tick();
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_nostale: got %h want %h", instr_valid, 1'b0);
        end
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, exp_instr(16'h0040), 16'h0040}) begin
            n_err++;
            $display("FAIL rd_first: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, exp_instr(16'h0040), 16'h0040});
        end
    endtask

    task automatic test_redirect_full;
        do_reset();
        repeat (10) tick();
        n_vec++;
        if ({mem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 16'd10}) begin
            n_err++;
            $display("FAIL rf_full: got %h want %h", {mem_req, instr_valid, instr_pc},
                     {1'b0, 1'b1, 16'd10});
        end
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== 33'd0) begin
            n_err++;
            $display("FAIL rf_flush: got %h want %h", {instr_valid, instr, instr_pc}, 33'd0);
        end
        n_vec++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0100}) begin
            n_err++;
            $display("FAIL rf_addr: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'h0100});
        end
        tick();
        tick();
        n_vec++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, exp_instr(16'h0100), 16'h0100}) begin
            n_err++;
            $display("FAIL rf_first: got %h want %h", {instr_valid, instr, instr_pc},
                     {1'b1, exp_instr(16'h0100), 16'h0100});
        end
    endtask

    task automatic test_wrap;
        do_reset();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        n_vec++;
        if ({mem_req, mem_addr} !== {1'b1, 16'hFFFE}) begin
            n_err++;
            $display("FAIL wrap_hi: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'hFFFE});
        end
        tick();
        n_vec++;
        if ({mem_req, mem_addr} !== {1'b1, 16'hFFFF}) begin
            n_err++;
            $display("FAIL wrap_lo: got %h want %h", {mem_req, mem_addr}, {1'b1, 16'hFFFF});
        end
        tick();
        n_vec++;
        if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !==
            {1'b1, 16'h0000, 1'b1, exp_instr(16'hFFFE), 16'hFFFE}) begin
            n_err++;
            $display("FAIL wrap_zero: got %h want %h",
                     {mem_req, mem_addr, instr_valid, instr, instr_pc},
                     {1'b1, 16'h0000, 1'b1, exp_instr(16'hFFFE), 16'hFFFE});
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        tick();
        tick();
        tick();
        ack_en = 1'b0;
        tick();
        n_vec++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'd12, 1'b1}) begin
            n_err++;
            $display("FAIL rm_busy: got %h want %h", {mem_req, mem_addr, instr_valid},
                     {1'b1, 16'd12, 1'b1});
        end
        Reset = 1'b1;
        tick();
        n_vec++;
        if ({mem_req, mem_addr, instr_valid, instr, instr_pc} !==
            {1'b0, 16'd10, 1'b0, 16'd0, 16'd0}) begin
            n_err++;
            $display("FAIL rm_reset: got %h want %h",
                     {mem_req, mem_addr, instr_valid, instr, instr_pc},
                     {1'b0, 16'd10, 1'b0, 16'd0, 16'd0});
        end
        Reset  = 1'b0;
        ack_en = 1'b1;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        Reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'd0;
        instr_ready = 1'b0;
        ack_en      = 1'b1;
        ack_wait    = 0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_latency();
        test_redirect_drop();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
